// File: rtl/instr_encoder_if.sv
// Purpose: operation-in / instruction-out handshake bundle for instr_encoder.
// Ports (as signals):
//   in_valid/in_ready  - operation transfer handshake
//   in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm - decoded operation
//   out_valid/out_ready - instruction word transfer handshake
//   out_instr, out_err  - encoded word and its error qualifier
// Modports: slave = encoder side, master = producer/consumer side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport slave (
    input  in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

  modport master (
    output in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Purpose: encode one decoded RV32I operation per transfer into a 32-bit
// instruction word, with a one-deep registered output stage. The LI
// pseudo-op expands to LUI (+ ADDI when the low part is non-zero).
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - instr_encoder_if.slave: operation in, instruction word out
module instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  localparam logic [3:0] K_OP     = 4'd0;
  localparam logic [3:0] K_OP_IMM = 4'd1;
  localparam logic [3:0] K_LOAD   = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_JAL    = 4'd5;
  localparam logic [3:0] K_JALR   = 4'd6;
  localparam logic [3:0] K_LUI    = 4'd7;
  localparam logic [3:0] K_AUIPC  = 4'd8;
  localparam logic [3:0] K_LI     = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic {ST_IDLE, ST_LI_LO} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic [31:0] pend_q, pend_d;

  logic        slot_free;
  logic        in_ready_c;
  logic        accept;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_pend;
  logic        fit12;
  logic        fit13;
  logic        fit21;
  logic [19:0] li_hi;
  logic [31:0] imm;

  // Combinational encoder for the presented operation.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_pend = '0;
    imm      = bus.in_imm;
    // Signed-range tests: the top bits must all equal the field's sign bit.
    fit12    = (&imm[31:11]) || !(|imm[31:11]);
    fit13    = (&imm[31:12]) || !(|imm[31:12]);
    fit21    = (&imm[31:20]) || !(|imm[31:20]);
    // Round up so that the sign-extended ADDI low part restores the value.
    li_hi    = 20'((imm + 32'h0000_0800) >> 12);
    case (bus.in_kind)
      K_OP: begin
        enc_word = {bus.in_alt ? F7_ALT : 7'b0, bus.in_rs2, bus.in_rs1,
                    bus.in_funct3, bus.in_rd, OPC_OP};
      end
      K_OP_IMM: begin
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101) begin
          enc_word = {(bus.in_funct3 == 3'b101 && bus.in_alt) ? F7_ALT : 7'b0,
                      imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OPC_OP_IMM};
          enc_err  = |imm[31:5];
        end else begin
          enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OPC_OP_IMM};
          enc_err  = !fit12;
        end
      end
      K_LOAD: begin
        enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OPC_LOAD};
        enc_err  = !fit12;
      end
      K_STORE: begin
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], OPC_STORE};
        enc_err  = !fit12;
      end
      K_BRANCH: begin
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:1], imm[11], OPC_BRANCH};
        enc_err  = !fit13 || imm[0];
      end
      K_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, OPC_JAL};
        enc_err  = !fit21 || imm[0];
      end
      K_JALR: begin
        enc_word = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OPC_JALR};
        enc_err  = !fit12;
      end
      K_LUI: begin
        enc_word = {imm[31:12], bus.in_rd, OPC_LUI};
        enc_err  = |imm[11:0];
      end
      K_AUIPC: begin
        enc_word = {imm[31:12], bus.in_rd, OPC_AUIPC};
        enc_err  = |imm[11:0];
      end
      K_LI: begin
        if (fit12) begin
          enc_word = {imm[11:0], 5'd0, 3'b000, bus.in_rd, OPC_OP_IMM};
        end else begin
          enc_word = {li_hi, bus.in_rd, OPC_LUI};
          enc_two  = |imm[11:0];
          enc_pend = {imm[11:0], bus.in_rd, 3'b000, bus.in_rd, OPC_OP_IMM};
        end
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && enc_two) state_d = ST_LI_LO;
      ST_LI_LO: if (slot_free)         state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and output-stage next values.
  always_comb begin
    slot_free   = !out_valid_q || bus.out_ready;
    in_ready_c  = (state_q == ST_IDLE) && slot_free;
    accept      = bus.in_valid && in_ready_c;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    pend_d      = pend_q;
    if (state_q == ST_LI_LO) begin
      if (slot_free) begin
        out_valid_d = 1'b1;
        out_instr_d = pend_q;
        out_err_d   = 1'b0;
        pend_d      = '0;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_err_d   = enc_err;
      if (enc_two) pend_d = enc_pend;
    end
  end

  // Output stage and pending ADDI register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      pend_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: self-checking bench for instr_encoder: directed vectors, backpressure,
// back-to-back streaming, reset during LI expansion and randomized traffic
// scored against an arithmetic reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_if bus_if ();

  instr_encoder #(.NOP_WORD(32'h0000_0013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  k;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    int          n;
    logic [31:0] w0;
    logic        e0;
    logic [31:0] w1;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    bus_if.in_kind   = k;
    bus_if.in_funct3 = f3;
    bus_if.in_alt    = alt;
    bus_if.in_rd     = rd;
    bus_if.in_rs1    = rs1;
    bus_if.in_rs2    = rs2;
    bus_if.in_imm    = imm;
  endtask

  // Reference model: instruction fields assembled with plain arithmetic.
  function automatic void model(input logic [3:0] kind, input logic [2:0] f3_i, input logic alt,
                                input logic [4:0] rd_i, input logic [4:0] rs1_i,
                                input logic [4:0] rs2_i, input logic [31:0] imm,
                                output int n, output logic [31:0] w0, output logic e0,
                                output logic [31:0] w1);
    logic [31:0] rd, rs1, rs2, f3, f7, sum, hi, lo;
    longint s;
    rd  = 32'(rd_i);
    rs1 = 32'(rs1_i);
    rs2 = 32'(rs2_i);
    f3  = 32'(f3_i);
    s   = longint'($signed(imm));
    n   = 1;
    e0  = 1'b0;
    w1  = 32'd0;
    case (kind)
      4'd0: begin
        f7 = alt ? 32'd32 : 32'd0;
        w0 = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h33;
      end
      4'd1: begin
        if (f3 == 32'd1 || f3 == 32'd5) begin
          f7 = (f3 == 32'd5 && alt) ? 32'd32 : 32'd0;
          w0 = (f7 << 25) + ((imm % 32) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
          e0 = (imm >= 32'd32);
        end else begin
          w0 = ((imm % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
          e0 = (s < -2048 || s > 2047);
        end
      end
      4'd2: begin
        w0 = ((imm % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h03;
        e0 = (s < -2048 || s > 2047);
      end
      4'd3: begin
        w0 = (((imm / 32) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
             + ((imm % 32) << 7) + 32'h23;
        e0 = (s < -2048 || s > 2047);
      end
      4'd4: begin
        w0 = (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25) + (rs2 << 20)
             + (rs1 << 15) + (f3 << 12) + (((imm / 2) % 16) << 8)
             + (((imm / 2048) % 2) << 7) + 32'h63;
        e0 = (s < -4096 || s > 4094 || (imm % 2) != 0);
      end
      4'd5: begin
        w0 = (((imm / 1048576) % 2) << 31) + (((imm / 2) % 1024) << 21)
             + (((imm / 2048) % 2) << 20) + (((imm / 4096) % 256) << 12)
             + (rd << 7) + 32'h6F;
        e0 = (s < -1048576 || s > 1048574 || (imm % 2) != 0);
      end
      4'd6: begin
        w0 = ((imm % 4096) << 20) + (rs1 << 15) + (rd << 7) + 32'h67;
        e0 = (s < -2048 || s > 2047);
      end
      4'd7, 4'd8: begin
        w0 = ((imm / 4096) << 12) + (rd << 7) + ((kind == 4'd7) ? 32'h37 : 32'h17);
        e0 = (imm % 4096) != 0;
      end
      4'd9: begin
        if (s >= -2048 && s <= 2047) begin
          w0 = ((imm % 4096) << 20) + (rd << 7) + 32'h13;
        end else begin
          sum = imm + 32'h800;
          hi  = sum / 4096;
          lo  = imm % 4096;
          w0  = ((hi % 1048576) << 12) + (rd << 7) + 32'h37;
          if (lo != 0) begin
            n  = 2;
            w1 = (lo << 20) + (rd << 15) + (rd << 7) + 32'h13;
          end
        end
      end
      default: begin
        w0 = 32'h13;
        e0 = 1'b1;
      end
    endcase
  endfunction

  task automatic test_reset();
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    set_op(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    tick();
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_instr !== 32'd0 || bus_if.out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b instr=%h err=%b required 0/00000000/0",
               bus_if.out_valid, bus_if.out_instr, bus_if.out_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", bus_if.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[11];
    bit   got;
    vecs[0]  = '{4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          1, 32'h002081B3, 1'b0, 32'd0};
    vecs[1]  = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   1, 32'hFE208EE3, 1'b0, 32'd0};
    vecs[2]  = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,          1, 32'h00208163, 1'b1, 32'd0};
    vecs[3]  = '{4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678,   2, 32'h123452B7, 1'b0, 32'h67828293};
    vecs[4]  = '{4'd9, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000FFF,   2, 32'h000010B7, 1'b0, 32'hFFF08093};
    vecs[5]  = '{4'd9, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00010000,   1, 32'h000100B7, 1'b0, 32'd0};
    vecs[6]  = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096,       1, 32'h00000093, 1'b1, 32'd0};
    vecs[7]  = '{4'd12, 3'd0, 1'b0, 5'd7, 5'd3, 5'd4, 32'd55,        1, 32'h00000013, 1'b1, 32'd0};
    vecs[8]  = '{4'd9, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF,   1, 32'hFFF00113, 1'b0, 32'd0};
    vecs[9]  = '{4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          1, 32'h40315093, 1'b0, 32'd0};
    vecs[10] = '{4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,       1, 32'h001000EF, 1'b0, 32'd0};
    bus_if.out_ready = 1'b1;
    foreach (vecs[i]) begin
      set_op(vecs[i].k, vecs[i].f3, vecs[i].alt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      bus_if.in_valid = 1'b1;
      #1;
      for (int g = 0; g < 20 && bus_if.in_ready !== 1'b1; g++) tick();
      got = (bus_if.in_ready === 1'b1);
      checks++;
      if (!got || bus_if.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_pre_accept: in_ready=%b out_valid=%b required 1/0",
                 i, bus_if.in_ready, bus_if.out_valid);
      end
      tick();
      bus_if.in_valid = 1'b0;
      #1;
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_instr !== vecs[i].w0 || bus_if.out_err !== vecs[i].e0) begin
        failures++;
        $display("FAIL dir%0d_word0: valid=%b instr=%h err=%b required 1/%h/%b",
                 i, bus_if.out_valid, bus_if.out_instr, bus_if.out_err, vecs[i].w0, vecs[i].e0);
      end
      if (vecs[i].n == 2) begin
        checks++;
        if (bus_if.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL dir%0d_li_in_ready: got %b required 0", i, bus_if.in_ready);
        end
        tick();
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_instr !== vecs[i].w1 || bus_if.out_err !== 1'b0) begin
          failures++;
          $display("FAIL dir%0d_word1: valid=%b instr=%h err=%b required 1/%h/0",
                   i, bus_if.out_valid, bus_if.out_instr, bus_if.out_err, vecs[i].w1);
        end
      end
      tick();
      #1;
      checks++;
      if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL dir%0d_drained: out_valid=%b in_ready=%b required 0/1",
                 i, bus_if.out_valid, bus_if.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bus_if.out_ready = 1'b0;
    set_op(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus_if.in_valid = 1'b1;
    tick();
    // A different op stays offered; it must not be taken while stalled.
    set_op(4'd1, 3'd0, 1'b0, 5'd9, 5'd9, 5'd0, 32'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_instr !== 32'h002081B3 ||
          bus_if.out_err !== 1'b0 || bus_if.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_c%0d: valid=%b instr=%h err=%b in_ready=%b required 1/002081b3/0/0",
                 c, bus_if.out_valid, bus_if.out_instr, bus_if.out_err, bus_if.in_ready);
      end
      tick();
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: out_valid=%b required 0", bus_if.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(4'd0, 3'd0, 1'b0, 5'(i + 1), 5'd1, 5'd2, 32'd0);
      bus_if.in_valid = 1'b1;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready%0d: got %b required 1", i, bus_if.in_ready);
      end
      tick();
      if (i == 3) bus_if.in_valid = 1'b0;
      #1;
      exp = 32'h00208033 + (32'(i + 1) << 7);
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_instr !== exp) begin
        failures++;
        $display("FAIL b2b_word%0d: valid=%b instr=%h required 1/%h",
                 i, bus_if.out_valid, bus_if.out_instr, exp);
      end
    end
    tick();
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: out_valid=%b required 0", bus_if.out_valid);
    end
  endtask

  task automatic test_reset_in_li();
    bus_if.out_ready = 1'b1;
    set_op(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    #1;
    checks++;
    if (bus_if.out_instr !== 32'h123452B7 || bus_if.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_li_lui: instr=%h in_ready=%b required 123452b7/0",
               bus_if.out_instr, bus_if.in_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_li_after: out_valid=%b in_ready=%b required 0/1",
               bus_if.out_valid, bus_if.in_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus_if.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_li_no_addi%0d: out_valid=%b instr=%h required 0",
                 c, bus_if.out_valid, bus_if.out_instr);
      end
    end
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic [32:0] head;
    logic [31:0] imm, w0, w1, prev_w;
    logic        e0, prev_e, stall_prev, exp_ready;
    int          n;
    stall_prev = 1'b0;
    prev_w     = '0;
    prev_e     = 1'b0;
    for (int cyc = 0; cyc < 1510; cyc++) begin
      tick();
      case ($urandom_range(0, 4))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        3:       imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 63));
      endcase
      set_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
      bus_if.in_valid  = (cyc < 1500) && ($urandom_range(0, 3) != 0);
      bus_if.out_ready = (cyc >= 1500) || ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && bus_if.out_ready);
      checks++;
      if (bus_if.out_valid !== (q.size() != 0) || bus_if.in_ready !== exp_ready) begin
        failures++;
        $display("FAIL rnd_hs c%0d: out_valid=%b in_ready=%b required %b/%b",
                 cyc, bus_if.out_valid, bus_if.in_ready, q.size() != 0, exp_ready);
      end
      if (stall_prev) begin
        checks++;
        if (bus_if.out_instr !== prev_w || bus_if.out_err !== prev_e) begin
          failures++;
          $display("FAIL rnd_hold c%0d: instr=%h err=%b required %h/%b",
                   cyc, bus_if.out_instr, bus_if.out_err, prev_w, prev_e);
        end
      end
      if (bus_if.out_valid === 1'b1 && bus_if.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_word c%0d: unexpected word %h", cyc, bus_if.out_instr);
        end else begin
          head = q.pop_front();
          if ({bus_if.out_err, bus_if.out_instr} !== head) begin
            failures++;
            $display("FAIL rnd_word c%0d: instr=%h err=%b required %h/%b",
                     cyc, bus_if.out_instr, bus_if.out_err, head[31:0], head[32]);
          end
        end
      end
      if (bus_if.in_valid && bus_if.in_ready === 1'b1) begin
        model(bus_if.in_kind, bus_if.in_funct3, bus_if.in_alt, bus_if.in_rd,
              bus_if.in_rs1, bus_if.in_rs2, bus_if.in_imm, n, w0, e0, w1);
        q.push_back({e0, w0});
        if (n == 2) q.push_back({1'b0, w1});
      end
      stall_prev = (bus_if.out_valid === 1'b1) && !bus_if.out_ready;
      prev_w     = bus_if.out_instr;
      prev_e     = bus_if.out_err;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain: %0d words never emitted, required 0", q.size());
    end
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_in_li();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
